wb_dst_pipe: RTL and testbench
==============================

# wb_dst_pipe

Destination-register tracking pipeline for the P5 five-stage MIPS core. It takes the decoded write-register number (rt, rd or 31, already chosen in D) plus the producer's Tnew. It carries them through the E, M and W stages with a per-stage Tnew countdown. From the tracked destinations it produces the D-stage stall request and the D-stage rs/rt forwarding selects. The outputs feed the D/E pipeline register enables and the D-stage GRF read-bypass muxes.

## Interface
Parameters:
- TW, 2, Tnew/Tuse width in bits (max value 3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- A3_D  in  5  destination register of the instruction in D; 0 means no write
- Tnew_D  in  TW  cycles after entering E until the result exists (jal 0, ALU 1, load 2)
- rs_D, rt_D  in  5 each  source registers read by the instruction in D
- Tuse_rs, Tuse_rt  in  TW each  cycles until the D instruction needs rs/rt (3 = not used)
- flush_E  in  1  insert a bubble into E on this edge
- stall  out  1  freeze PC and the F/D register, bubble E
- fwd_rs_D, fwd_rt_D  out  2 each  0 = GRF, 1 = from W, 2 = from M, 3 = from E
- A3_E, A3_M, A3_W  out  5 each  tracked destinations
- Tnew_E, Tnew_M  out  TW each  remaining cycles

## Operation
- Stage registers hold {A3, Tnew} for E, M and W. W Tnew is implicitly 0.
- Every edge (no enable), the stages advance as follows:
  - W ← M.
  - M ← {A3_E, sat_dec(Tnew_E)}, where sat_dec(x) = x = 0 ? 0 : x − 1.
  - E ← {A3_D, Tnew_D}, unless a bubble is inserted.
- A bubble is inserted into E when stall = 1 or flush_E = 1 (either or both). A bubble is {0, 0}.
- A stage "matches" register r when its A3 ≠ 0 and its A3 = r. Register $0 never matches.
- stall = OR over src ∈ {rs, rt} of:
  - (match_E(src) && Tnew_E > Tuse_src)
  - (match_M(src) && Tnew_M > Tuse_src)
  - Unsigned compare.
- Forward select, per source, in priority order (first match wins):
  - E matches → 3 if Tnew_E = 0, else 0.
  - M matches → 2 if Tnew_M = 0, else 0.
  - W matches → 1.
  - Otherwise → 0.
- A younger match always shadows an older match, even when the younger result is not yet ready. The 0 select in that case is resolved by the stall or by downstream E-stage forwarding.
- stall and the fwd selects are purely combinational from the current stage registers and the D inputs.

## Timing
- Reset (reset = 0, asynchronous): all stage registers are 0, so stall = 0, all fwd = 0, and all A3/Tnew outputs = 0. Normal operation resumes on the first edge after reset deasserts.
- Reset mid-operation clears everything immediately; no partial advance.
- Latency:
  - D → E A3 visible 1 edge after capture.
  - E → M and M → W take 1 edge each.
  - Tnew_M = Tnew_E − 1 (saturated) on the same edge.
- A stall persists until the offending producer's Tnew drops to ≤ Tuse. Load-use with Tuse = 1 gives exactly 1 stall cycle; load-branch with Tuse = 0 gives 2.
- With stall and flush_E in the same cycle, a single bubble enters E. The D instruction is held by the external stall.
- Tnew_D = 3 saturates to 0 after three advances; no wrap to 3.

## Configuration
- WB_DST_PIPE_W_FWD_EN defined: a W-stage match produces select 1.
- Undefined: W matches are ignored (select 0). The GRF must provide write-before-read bypass. E and M behaviour is unchanged.

## Test plan
- Reset: hold reset = 0 after arbitrary traffic → all outputs 0 asynchronously, before the next edge.
- Load-use: A3_D = 8, Tnew_D = 2, then rs_D = 8, Tuse_rs = 1 → stall = 1 for one cycle with E bubbled. Next cycle: A3_M = 8, Tnew_M = 1, stall = 0, fwd_rs_D = 0.
- ALU → branch: A3_D = 9, Tnew_D = 1, then rs_D = rt_D = 9, Tuse = 0 → stall for 1 cycle. Then fwd_rs_D = fwd_rt_D = 2, stall = 0.
- jal: A3_D = 31, Tnew_D = 0, then rs_D = 31, Tuse_rs = 0 → stall = 0, fwd_rs_D = 3. Two cycles later, with no intervening writer and the macro defined → fwd_rs_D = 1.
- $0: A3_D = 0, Tnew_D = 2, then rs_D = 0, Tuse_rs = 0 → stall = 0, fwd = 0.
- Macro off: the W-only match case from the jal test gives fwd_rs_D = 0. flush_E = 1 with A3_D = 5 → A3_E = 0 next cycle.

Source files
------------

// File: rtl/wb_dst_pipe.sv
// rtl/wb_dst_pipe.sv - destination/Tnew tracking across E, M, W with D-stage stall and forward selects
// Define WB_DST_PIPE_W_FWD_EN to let a W-stage match produce forward select 1.
module wb_dst_pipe #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    A3_D,
    input  logic [TW-1:0] Tnew_D,
    input  logic [4:0]    rs_D,
    input  logic [4:0]    rt_D,
    input  logic [TW-1:0] Tuse_rs,
    input  logic [TW-1:0] Tuse_rt,
    input  logic          flush_E,
    output logic          stall,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic [4:0]    A3_E,
    output logic [4:0]    A3_M,
    output logic [4:0]    A3_W,
    output logic [TW-1:0] Tnew_E,
    output logic [TW-1:0] Tnew_M
);

    logic [4:0]    r_a3_e;
    logic [4:0]    r_a3_m;
    logic [4:0]    r_a3_w;
    logic [TW-1:0] r_tnew_e;
    logic [TW-1:0] r_tnew_m;

    logic          w_me_rs;
    logic          w_me_rt;
    logic          w_mm_rs;
    logic          w_mm_rt;
    logic          w_stall;
    logic          w_bubble;
    logic [TW-1:0] w_tnew_e_dec;
    logic [1:0]    w_fwd_rs;
    logic [1:0]    w_fwd_rt;

    // $0 is never a real destination, so a zero A3 never matches
    assign w_me_rs = (r_a3_e != 5'd0) && (r_a3_e == rs_D);
    assign w_me_rt = (r_a3_e != 5'd0) && (r_a3_e == rt_D);
    assign w_mm_rs = (r_a3_m != 5'd0) && (r_a3_m == rs_D);
    assign w_mm_rt = (r_a3_m != 5'd0) && (r_a3_m == rt_D);

`ifdef WB_DST_PIPE_W_FWD_EN
    logic w_mw_rs;
    logic w_mw_rt;
    assign w_mw_rs = (r_a3_w != 5'd0) && (r_a3_w == rs_D);
    assign w_mw_rt = (r_a3_w != 5'd0) && (r_a3_w == rt_D);
`endif

    assign w_stall = (w_me_rs && (r_tnew_e > Tuse_rs)) ||
                     (w_mm_rs && (r_tnew_m > Tuse_rs)) ||
                     (w_me_rt && (r_tnew_e > Tuse_rt)) ||
                     (w_mm_rt && (r_tnew_m > Tuse_rt));

    assign w_bubble     = w_stall || flush_E;
    assign w_tnew_e_dec = (r_tnew_e == '0) ? '0 : (r_tnew_e - TW'(1));

    // The youngest matching stage wins even when its value is not ready yet
    always_comb begin
        w_fwd_rs = 2'd0;
        if (w_me_rs) begin
            w_fwd_rs = (r_tnew_e == '0) ? 2'd3 : 2'd0;
        end else if (w_mm_rs) begin
            w_fwd_rs = (r_tnew_m == '0) ? 2'd2 : 2'd0;
        end
`ifdef WB_DST_PIPE_W_FWD_EN
        else if (w_mw_rs) begin
            w_fwd_rs = 2'd1;
        end
`endif
    end

    always_comb begin
        w_fwd_rt = 2'd0;
        if (w_me_rt) begin
            w_fwd_rt = (r_tnew_e == '0) ? 2'd3 : 2'd0;
        end else if (w_mm_rt) begin
            w_fwd_rt = (r_tnew_m == '0) ? 2'd2 : 2'd0;
        end
`ifdef WB_DST_PIPE_W_FWD_EN
        else if (w_mw_rt) begin
            w_fwd_rt = 2'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a3_e   <= 5'd0;
            r_tnew_e <= '0;
            r_a3_m   <= 5'd0;
            r_tnew_m <= '0;
            r_a3_w   <= 5'd0;
        end else begin
            r_a3_w   <= r_a3_m;
            r_a3_m   <= r_a3_e;
            r_tnew_m <= w_tnew_e_dec;
            if (w_bubble) begin
                r_a3_e   <= 5'd0;
                r_tnew_e <= '0;
            end else begin
                r_a3_e   <= A3_D;
                r_tnew_e <= Tnew_D;
            end
        end
    end

    assign stall    = w_stall;
    assign fwd_rs_D = w_fwd_rs;
    assign fwd_rt_D = w_fwd_rt;
    assign A3_E     = r_a3_e;
    assign A3_M     = r_a3_m;
    assign A3_W     = r_a3_w;
    assign Tnew_E   = r_tnew_e;
    assign Tnew_M   = r_tnew_m;

endmodule

// File: tb/tb_wb_dst_pipe.sv
// tb/tb_wb_dst_pipe.sv - scoreboard bench for wb_dst_pipe with directed hand-computed vectors
module tb_wb_dst_pipe;

`ifdef WB_DST_PIPE_W_FWD_EN
    localparam logic [1:0] WF = 2'd1;
`else
    localparam logic [1:0] WF = 2'd0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] A3_D = 5'd0;
    logic [1:0] Tnew_D = 2'd0;
    logic [4:0] rs_D = 5'd0;
    logic [4:0] rt_D = 5'd0;
    logic [1:0] Tuse_rs = 2'd3;
    logic [1:0] Tuse_rt = 2'd3;
    logic       flush_E = 1'b0;
    logic       stall;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [4:0] A3_E;
    logic [4:0] A3_M;
    logic [4:0] A3_W;
    logic [1:0] Tnew_E;
    logic [1:0] Tnew_M;

    int n_cmp = 0;
    int n_err = 0;

    // {stall, fwd_rs, fwd_rt, A3_E, Tnew_E, A3_M, Tnew_M, A3_W}
    logic [23:0] exp_q[$];
    string       name_q[$];

    wb_dst_pipe #(.TW(2)) dut (
        .clk(clk), .reset(reset), .A3_D(A3_D), .Tnew_D(Tnew_D),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
        .flush_E(flush_E), .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        logic [23:0] got;
        logic [23:0] want;
        string       nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = {stall, fwd_rs_D, fwd_rt_D, A3_E, Tnew_E, A3_M, Tnew_M, A3_W};
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL %s: got stall=%0b frs=%0d frt=%0d E=%0d/%0d M=%0d/%0d W=%0d required stall=%0b frs=%0d frt=%0d E=%0d/%0d M=%0d/%0d W=%0d",
                             nm, got[23], got[22:21], got[20:19], got[18:14], got[13:12], got[11:7], got[6:5], got[4:0],
                             want[23], want[22:21], want[20:19], want[18:14], want[13:12], want[11:7], want[6:5], want[4:0]);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic rst,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic [4:0] rs, input logic [1:0] urs,
                       input logic [4:0] rt, input logic [1:0] urt, input logic fl,
                       input logic x_st, input logic [1:0] x_frs, input logic [1:0] x_frt,
                       input logic [4:0] x_a3e, input logic [1:0] x_te,
                       input logic [4:0] x_a3m, input logic [1:0] x_tm, input logic [4:0] x_a3w);
        @(posedge clk);
        #1;
        reset   = rst;
        A3_D    = a3;
        Tnew_D  = tn;
        rs_D    = rs;
        Tuse_rs = urs;
        rt_D    = rt;
        Tuse_rt = urt;
        flush_E = fl;
        exp_q.push_back({x_st, x_frs, x_frt, x_a3e, x_te, x_a3m, x_tm, x_a3w});
        name_q.push_back(nm);
    endtask

    initial begin
        //   name         rst  A3 Tn  rs Urs rt Urt fl | st frs frt A3E TE A3M TM A3W
        cyc("reset0",     0,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("lu_issue",   1,   8, 2,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("lu_stall",   1,  10, 1,  8, 1,  0, 3,  0,   1, 0,  0,   8, 2,  0, 0,  0);
        cyc("lu_go",      1,  10, 1,  8, 1,  0, 3,  0,   0, 0,  0,   0, 0,  8, 1,  0);
        cyc("alu_e_rt",   1,   0, 0,  8, 3, 10, 0,  0,   1, WF, 0,  10, 1,  0, 0,  8);
        cyc("alu_m",      1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0, 10, 0,  0);
        cyc("alu_w",      1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0, 10);
        cyc("br_issue",   1,   9, 1,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("br_stall",   1,   0, 0,  9, 0,  9, 0,  0,   1, 0,  0,   9, 1,  0, 0,  0);
        cyc("br_fwd_m",   1,   0, 0,  9, 0,  9, 0,  0,   0, 2,  2,   0, 0,  9, 0,  0);
        cyc("br_w",       1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  9);
        cyc("jal_issue",  1,  31, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("jal_fwd_e",  1,   0, 0, 31, 0,  0, 3,  0,   0, 3,  0,  31, 0,  0, 0,  0);
        cyc("jal_fwd_m",  1,   0, 0, 31, 0,  0, 3,  0,   0, 2,  0,   0, 0, 31, 0,  0);
        cyc("jal_fwd_w",  1,   0, 0, 31, 0,  0, 3,  0,   0, WF, 0,   0, 0,  0, 0, 31);
        cyc("r0_issue",   1,   0, 2,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("r0_nomatch", 1,   0, 0,  0, 0,  0, 3,  0,   0, 0,  0,   0, 2,  0, 0,  0);
        cyc("r0_m",       1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 1,  0);
        cyc("flush",      1,   5, 1,  0, 3,  0, 3,  1,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("flush_e0",   1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("lb_issue",   1,   7, 2,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("lb_st_fl",   1,  12, 1,  7, 0,  0, 3,  1,   1, 0,  0,   7, 2,  0, 0,  0);
        cyc("lb_stall2",  1,  12, 1,  7, 0,  0, 3,  0,   1, 0,  0,   0, 0,  7, 1,  0);
        cyc("lb_go",      1,  12, 1,  7, 0,  0, 3,  0,   0, WF, 0,   0, 0,  0, 0,  7);
        cyc("lb_held",    1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,  12, 1,  0, 0,  0);
        cyc("t3_issue",   1,   4, 3,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0, 12, 0,  0);
        cyc("t3_e",       1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   4, 3,  0, 0, 12);
        cyc("t3_m_eq",    1,   0, 0,  4, 2,  0, 3,  0,   0, 0,  0,   0, 0,  4, 2,  0);
        cyc("t3_w",       1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  4);
        cyc("mix_a",      1,   6, 1,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("mix_b",      1,  11, 2,  0, 3,  0, 3,  0,   0, 0,  0,   6, 1,  0, 0,  0);
        cyc("mix_c",      1,  13, 2,  6, 0, 11, 3,  0,   0, 2,  0,  11, 2,  6, 0,  0);
        cyc("reset_mid",  0,   0, 0, 13, 0, 11, 0,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("reset_hold", 0,   3, 1, 13, 0, 11, 0,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("reset_rel",  1,   3, 1,  0, 3,  0, 3,  0,   0, 0,  0,   0, 0,  0, 0,  0);
        cyc("post_reset", 1,   0, 0,  0, 3,  0, 3,  0,   0, 0,  0,   3, 1,  0, 0,  0);
        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
